// File: rtl/compute_dispatch_pkg.sv
// Shared types and header-byte layout for the compute dispatch feeder.
package dispatch_pkg;

    localparam int BYTE_W = 8;

    // Header byte: [7] dest unit, [6:4] reserved (must be zero), [3:0] opcode
    localparam int                HDR_DEST_BIT  = 7;
    localparam int                HDR_OPC_MSB   = 3;
    localparam logic [BYTE_W-1:0] HDR_RSVD_MASK = 8'h70;

    typedef enum logic [1:0] {
        HDR,
        GET_A,
        GET_B
    } state_t;

    typedef struct packed {
        logic              dest;
        logic [3:0]        opcode;
        logic [BYTE_W-1:0] a;
        logic [BYTE_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/compute_dispatch_if.sv
// Pad byte stream in, two compute-unit command handshakes out, drop status.
interface compute_dispatch_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = 8,
    parameter int DROP_W     = 4
);
    logic                          in_valid;
    logic                          in_sof;
    logic [OP_W-1:0]               in_data;
    logic                          in_ready;
    logic [3:0]                    cmd_opcode;
    logic [OP_W-1:0]               cmd_a;
    logic [OP_W-1:0]               cmd_b;
    logic                          cu0_valid;
    logic                          cu0_ready;
    logic                          cu1_valid;
    logic                          cu1_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          err_sticky;
    logic [DROP_W-1:0]             drop_count;
    logic                          err_clr;

    modport slave (
        input  in_valid, in_sof, in_data, cu0_ready, cu1_ready, err_clr,
        output in_ready, cmd_opcode, cmd_a, cmd_b, cu0_valid, cu1_valid,
               fifo_count, err_sticky, drop_count
    );

    modport master (
        output in_valid, in_sof, in_data, cu0_ready, cu1_ready, err_clr,
        input  in_ready, cmd_opcode, cmd_a, cmd_b, cu0_valid, cu1_valid,
               fifo_count, err_sticky, drop_count
    );
endinterface

// File: rtl/compute_dispatch_cmd_fifo.sv
// Synchronous command FIFO; head entry visible combinationally from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: caller must not push when full nor pop when empty.
module cmd_fifo
    import dispatch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  cmd_t        push_dat,
    input  logic        pop,
    output cmd_t        head_dat,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Power-of-two depth lets the pointers wrap without compare logic
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/compute_dispatch.sv
// Assembles 3-byte pad frames into commands and issues them in order to CU0/CU1.
// Latency: third byte accepted at cycle N -> unit valid at N+1 (empty FIFO).
// Backpressure: in_ready drops only in GET_B with FIFO full; strict head-of-line.
module compute_dispatch
    import dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = BYTE_W,
    parameter int DROP_W     = 4
) (
    input logic               clk,
    input logic               rst,
    compute_dispatch_if.slave bus
);
    localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_t            state_q, state_d;
    logic              dest_q;
    logic [3:0]        opc_q;
    logic [OP_W-1:0]   a_q;
    logic              accept, hdr_ok, hdr_ld, a_ld, push, pop, full, empty;
    logic [1:0]        drop_inc;
    logic              err_q;
    logic [DROP_W-1:0] drop_q;
    logic [CW-1:0]     count;
    cmd_t              push_cmd, head, last_cmd, cmd_out;

    assign accept = bus.in_valid && bus.in_ready;
    assign hdr_ok = bus.in_sof && ((bus.in_data & HDR_RSVD_MASK) == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= HDR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        hdr_ld   = 1'b0;
        a_ld     = 1'b0;
        push     = 1'b0;
        drop_inc = 2'd0;
        if (accept) begin
            if (state_q != HDR && bus.in_sof) begin
                // Abort costs one drop; the byte is then judged as a fresh header
                drop_inc = hdr_ok ? 2'd1 : 2'd2;
                hdr_ld   = hdr_ok;
                state_d  = hdr_ok ? GET_A : HDR;
            end else begin
                case (state_q)
                    HDR: begin
                        if (hdr_ok) begin
                            hdr_ld  = 1'b1;
                            state_d = GET_A;
                        end else begin
                            drop_inc = 2'd1;
                        end
                    end
                    GET_A: begin
                        a_ld    = 1'b1;
                        state_d = GET_B;
                    end
                    GET_B: begin
                        push    = 1'b1;
                        state_d = HDR;
                    end
                    default: state_d = HDR;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dest_q <= 1'b0;
            opc_q  <= '0;
            a_q    <= '0;
        end else begin
            if (hdr_ld) begin
                dest_q <= bus.in_data[HDR_DEST_BIT];
                opc_q  <= bus.in_data[HDR_OPC_MSB:0];
            end
            if (a_ld) a_q <= bus.in_data;
        end
    end

    assign push_cmd = '{dest: dest_q, opcode: opc_q, a: a_q, b: bus.in_data};

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_cmd),
        .pop      (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign pop = !empty && (head.dest ? bus.cu1_ready : bus.cu0_ready);

    // Outputs hold the last issued command while the FIFO is empty
    always_ff @(posedge clk) begin
        if (rst)      last_cmd <= '0;
        else if (pop) last_cmd <= head;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.err_clr) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop_inc != 2'd0) begin
            err_q <= 1'b1;
            if (drop_q > DROP_MAX - DROP_W'(drop_inc)) drop_q <= DROP_MAX;
            else                                       drop_q <= drop_q + DROP_W'(drop_inc);
        end
    end

    assign cmd_out        = empty ? last_cmd : head;
    assign bus.cmd_opcode = cmd_out.opcode;
    assign bus.cmd_a      = cmd_out.a;
    assign bus.cmd_b      = cmd_out.b;
    assign bus.cu0_valid  = !empty && !head.dest;
    assign bus.cu1_valid  = !empty && head.dest;
    assign bus.in_ready   = !(state_q == GET_B && full);
    assign bus.fifo_count = count;
    assign bus.err_sticky = err_q;
    assign bus.drop_count = drop_q;

endmodule
